// File: rtl/uart_msg_scheduler_pkg.sv
// uart_msg_scheduler shared constants: ASCII frame bytes,
// colour codes and scheduler state encoding.
package uart_msg_pkg;

  localparam logic [7:0] ASC_HASH = 8'h23;
  localparam logic [7:0] ASC_DASH = 8'h2D;
  localparam logic [7:0] ASC_S    = 8'h53;
  localparam logic [7:0] ASC_I    = 8'h49;
  localparam logic [7:0] ASC_W    = 8'h57;
  localparam logic [7:0] ASC_F    = 8'h46;
  localparam logic [7:0] ASC_C    = 8'h43;
  localparam logic [7:0] ASC_T    = 8'h54;
  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_A    = 8'h41;

  localparam logic [2:0] COL_NONE = 3'd0;
  localparam logic [2:0] COL_FI   = 3'd1;
  localparam logic [2:0] COL_CT   = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

  function automatic logic [7:0] hex_digit(
    input logic [7:0] v
  );
    if (v < 8'd10) return ASC_ZERO + v;
    return ASC_A + v - 8'd10;
  endfunction

endpackage

// File: rtl/uart_msg_scheduler_if.sv
// Handshake bundles for uart_msg_scheduler: colour event
// input and the byte-level UART TX start/busy/done port.
interface uart_msg_ev_if #(
  parameter int NODE_W = 4
);
  logic              ev_valid;
  logic [2:0]        ev_color;
  logic [NODE_W-1:0] ev_node;
  logic              ev_ready;

  modport master (
    output ev_valid, ev_color, ev_node,
    input  ev_ready
  );
  modport slave (
    input  ev_valid, ev_color, ev_node,
    output ev_ready
  );
endinterface

interface uart_msg_tx_if;
  logic [7:0] o_tx_byte;
  logic       o_tx_start;
  logic       i_tx_busy;
  logic       i_tx_done;

  modport master (
    output o_tx_byte, o_tx_start,
    input  i_tx_busy, i_tx_done
  );
  modport slave (
    input  o_tx_byte, o_tx_start,
    output i_tx_busy, i_tx_done
  );
endinterface

// File: rtl/uart_msg_scheduler_fifo.sv
// msg_event_fifo: synchronous FIFO of {color, node} events,
// power-of-two depth, pointers wrap naturally.
import uart_msg_pkg::*;

module msg_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
    if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler: expands queued colour events into 10-byte
// ASCII frames for the UART TX. MSG_DEDUP_EN drops repeats.
import uart_msg_pkg::*;

module uart_msg_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int NODE_W     = 4
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  uart_msg_ev_if.slave ev,
  uart_msg_tx_if.master tx,
  output logic         o_busy,
  output logic         o_msg_done,
  output logic         o_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 3 + NODE_W;

  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic              ev_real;
  logic              is_dup;
  logic              push;
  logic              pop;

  sched_state_e      state_q;
  logic [3:0]        idx_q;
  logic [2:0]        color_q;
  logic [NODE_W-1:0] node_q;
  logic [7:0]        byte_q;
  logic              start_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;

  logic [7:0]        c1;
  logic [7:0]        c2;
  logic [7:0]        byte_mux;

  assign ev_real = ev.ev_valid && (ev.ev_color != COL_NONE);
  assign ev.ev_ready = (fifo_cnt != CW'(FIFO_DEPTH));

`ifdef MSG_DEDUP_EN
  logic [EW-1:0] last_q;
  // Reset value has colour 0, which never matches a real event.
  assign is_dup = ({ev.ev_color, ev.ev_node} == last_q);
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) last_q <= '0;
    else if (push) last_q <= {ev.ev_color, ev.ev_node};
  end
`else
  assign is_dup = 1'b0;
`endif

  assign push = ev_real && ev.ev_ready && !is_dup;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;

  msg_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i   (CLOCK),
    .rst_ni  (RESET_N),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({ev.ev_color, ev.ev_node}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    c1 = ASC_C;
    c2 = ASC_S;
    unique case (1'b1)
      (color_q == COL_FI): begin
        c1 = ASC_F;
        c2 = ASC_I;
      end
      (color_q == COL_CT): begin
        c1 = ASC_C;
        c2 = ASC_T;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_mux = ASC_HASH;
    case (idx_q)
      4'd0:    byte_mux = ASC_S;
      4'd1:    byte_mux = ASC_I;
      4'd2:    byte_mux = ASC_DASH;
      4'd3:    byte_mux = ASC_W;
      4'd4:    byte_mux = hex_digit(8'(node_q));
      4'd5:    byte_mux = ASC_DASH;
      4'd6:    byte_mux = c1;
      4'd7:    byte_mux = c2;
      4'd8:    byte_mux = ASC_DASH;
      default: byte_mux = ASC_HASH;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      color_q <= '0;
      node_q  <= '0;
      byte_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (ev_real && fifo_full && !is_dup) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            color_q <= head[EW-1 -: 3];
            node_q  <= head[NODE_W-1:0];
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!tx.i_tx_busy) begin
            byte_q  <= byte_mux;
            start_q <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx.i_tx_done) begin
            if (idx_q == 4'd9) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= ST_ISSUE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx.o_tx_byte  = byte_q;
  assign tx.o_tx_start = start_q;
  assign o_busy        = busy_q;
  assign o_msg_done    = done_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Self-checking bench for uart_msg_scheduler: UART byte model,
// frame-level reference queue and directed plus random steps.
module tb_uart_msg_scheduler;
  localparam int DEPTH = 4;
  localparam int NW    = 4;
`ifdef MSG_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  logic o_busy;
  logic o_msg_done;
  logic o_overflow;

  uart_msg_ev_if #(.NODE_W(NW)) ev ();
  uart_msg_tx_if tx ();

  uart_msg_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .NODE_W     (NW)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .ev         (ev),
    .tx         (tx),
    .o_busy     (o_busy),
    .o_msg_done (o_msg_done),
    .o_overflow (o_overflow)
  );

  always #5 CLOCK = ~CLOCK;

  logic       u_busy = 1'b0;
  logic       u_done = 1'b0;
  int         u_cnt = 0;
  int         byte_t = 10;
  logic       hold_busy = 1'b0;
  logic       spur = 1'b0;
  logic [7:0] cap [0:4095];
  int         cap_n = 0;
  int         done_n = 0;
  int         dbl_n = 0;
  logic       prev_start = 1'b0;

  assign tx.i_tx_busy = u_busy | hold_busy;
  assign tx.i_tx_done = u_done | spur;

  always @(posedge CLOCK) begin
    if (u_cnt > 1) u_cnt <= u_cnt - 1;
    else if (u_cnt == 1) begin
      u_cnt  <= 0;
      u_busy <= 1'b0;
      u_done <= 1'b1;
    end else u_done <= 1'b0;
    if (tx.o_tx_start) begin
      cap[cap_n % 4096] <= tx.o_tx_byte;
      cap_n  <= cap_n + 1;
      u_busy <= 1'b1;
      u_cnt  <= byte_t;
    end
    if (tx.o_tx_start && prev_start) dbl_n <= dbl_n + 1;
    if (o_msg_done) done_n <= done_n + 1;
    prev_start <= tx.o_tx_start;
  end

  int         cmp_n = 0;
  int         err_n = 0;
  int         acc = 0;
  int         pops = 0;
  int         acc_base = 0;
  int         cap_base = 0;
  int         done_base = 0;
  logic       busy_prev = 1'b0;
  logic       exp_ovf = 1'b0;
  logic [6:0] last = '0;
  logic [7:0] exp_b [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    cmp_n++;
    assert (obs === exp_v) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic string frame_str(input int c, input int n);
    string hex;
    string cc;
    hex = "0123456789ABCDEF";
    if (c == 1) cc = "FI";
    else if (c == 2) cc = "CT";
    else cc = "CS";
    return {"SI-W", hex.substr(n, n), "-", cc, "-#"};
  endfunction

  task automatic push_frame(input int c, input int n);
    string s;
    s = frame_str(c, n);
    for (int i = 0; i < 10; i++) exp_b.push_back(s[i]);
  endtask

  task automatic seg_start();
    cap_base  = cap_n;
    done_base = done_n;
    acc_base  = acc;
    exp_b.delete();
  endtask

  task automatic step(input logic v, input logic [2:0] c,
                      input logic [NW-1:0] n);
    logic full;
    full = ((acc - pops) == DEPTH);
    chk("ev_ready", ev.ev_ready, !full);
    ev.ev_valid = v;
    ev.ev_color = c;
    ev.ev_node  = n;
    if (v && c != 3'd0) begin
      if (DEDUP && {c, n} == last) begin
      end else if (full) exp_ovf = 1'b1;
      else begin
        acc++;
        last = {c, n};
        push_frame(c, n);
      end
    end
    @(posedge CLOCK);
    #1;
    ev.ev_valid = 1'b0;
    if (o_busy && !busy_prev) pops++;
    busy_prev = o_busy;
    chk("overflow", o_overflow, exp_ovf);
  endtask

  task automatic do_reset(input int cycles);
    RESET_N = 1'b0;
    ev.ev_valid = 1'b0;
    repeat (cycles) @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    acc = 0;
    pops = 0;
    busy_prev = 1'b0;
    exp_ovf = 1'b0;
    last = '0;
    seg_start();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_byte"}, tx.o_tx_byte, 0);
    chk({tag, "_start"}, tx.o_tx_start, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_msg_done, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
    chk({tag, "_ready"}, ev.ev_ready, 1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (!(acc == pops && !o_busy) && k < 6000) begin
      step(1'b0, 3'd0, '0);
      k++;
    end
    chk({tag, "_drain"}, (acc == pops && !o_busy), 1);
    repeat (3) step(1'b0, 3'd0, '0);
  endtask

  task automatic check_stream(input string tag);
    int n;
    n = cap_n - cap_base;
    chk({tag, "_len"}, n, exp_b.size());
    for (int i = 0; i < exp_b.size() && i < n; i++)
      chk({tag, "_byte"}, cap[(cap_base + i) % 4096], exp_b[i]);
    chk({tag, "_frames"}, done_n - done_base, acc - acc_base);
  endtask

  initial begin
    ev.ev_valid = 1'b0;
    ev.ev_color = '0;
    ev.ev_node  = '0;

    do_reset(3);
    chk_reset_outs("rst");

    step(1'b1, 3'd1, 4'd3);
    step(1'b0, 3'd0, '0);
    chk("lat_busy", o_busy, 1);
    chk("lat_nostart", tx.o_tx_start, 0);
    step(1'b0, 3'd0, '0);
    chk("lat_start", tx.o_tx_start, 1);
    chk("lat_byte0", tx.o_tx_byte, 8'h53);
    drain("single");
    check_stream("single");

    seg_start();
    step(1'b1, 3'd2, 4'd12);
    step(1'b1, 3'd5, 4'd0);
    drain("colour");
    check_stream("colour");

    seg_start();
    hold_busy = 1'b1;
    step(1'b1, 3'd3, 4'd7);
    repeat (50) step(1'b0, 3'd0, '0);
    chk("hold_nostart", cap_n - cap_base, 0);
    chk("hold_busy", o_busy, 1);
    hold_busy = 1'b0;
    drain("hold");
    check_stream("hold");
    spur = 1'b1;
    step(1'b0, 3'd0, '0);
    spur = 1'b0;
    repeat (3) step(1'b0, 3'd0, '0);
    chk("spur_idle", o_busy, 0);
    chk("spur_nobyte", cap_n - cap_base, exp_b.size());

    seg_start();
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++)
      step(1'b1, 3'((i % 3) + 1), 4'(i + 8));
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_ready", ev.ev_ready, 0);
    hold_busy = 1'b0;
    drain("ovf");
    check_stream("ovf");
    chk("ovf_frames5", done_n - done_base, 5);

    do_reset(2);
    chk_reset_outs("rst2");
    step(1'b1, 3'd4, 4'd9);
    for (int k = 0; k < 2000 && (cap_n - cap_base) < 5; k++)
      step(1'b0, 3'd0, '0);
    chk("mid_reached", (cap_n - cap_base) >= 5, 1);
    do_reset(2);
    chk_reset_outs("midrst");
    step(1'b1, 3'd3, 4'd10);
    drain("midrst");
    check_stream("midrst");

`ifdef MSG_DEDUP_EN
    do_reset(2);
    step(1'b1, 3'd1, 4'd3);
    step(1'b1, 3'd1, 4'd3);
    step(1'b1, 3'd2, 4'd3);
    drain("dedup");
    check_stream("dedup");
    chk("dedup_frames2", done_n - done_base, 2);
    chk("dedup_ovf", o_overflow, 0);
`endif

    do_reset(2);
    byte_t = $urandom_range(1, 4);
    for (int k = 0; k < 1500; k++) begin
      hold_busy = ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 14) == 0, 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)));
    end
    hold_busy = 1'b0;
    drain("rand");
    check_stream("rand");

    chk("no_double_start", dbl_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
